// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave
//   AXI4-Lite slave backed by a word-addressed register memory with byte
//   strobes. The write and read channels run independent two-state FSMs,
//   each with one transaction outstanding and fully registered responses.
//
// Ports
//   s0_axi_aclk / s0_axi_aresetn : clock (rising edge) and async active-low reset
//   s0_axi_aw*  : write address channel (awaddr, awvalid, awready)
//   s0_axi_w*   : write data channel (wdata, wstrb, wvalid, wready); the
//                 wstrb MSB is ignored
//   s0_axi_b*   : write response (bresp 1 = OKAY / 0 = error, bvalid, bready)
//   s0_axi_ar*  : read address channel (araddr, arvalid, arready)
//   s0_axi_r*   : read data channel (rdata, rresp 1 = OKAY / 0 = error,
//                 rvalid, rready)
//
// Handshake: a transfer happens on the rising edge where valid and ready are
// both 1. A source keeps valid and its payload stable until that edge. This
// slave drops ready for a channel once it has taken one beat and raises it
// again only after the response has been accepted.

module axi_lite_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                  s0_axi_aclk,
    input  logic                  s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0] s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic                  s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic                  s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready
);

    localparam int          NB      = DATA_WIDTH / 8;
    localparam int          IDX_W   = ADDR_WIDTH - 2;
    localparam int          MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = MEM_DEPTH;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              r_wstate;
    r_state_t              r_rstate;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  r_aw_held;
    logic [IDX_W-1:0]      r_aw_idx;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic                  r_bresp;

    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rresp;

    // Address low bits and the wstrb MSB carry no meaning for this memory.
    logic [4:0]            w_unused_bits;
    assign w_unused_bits = {s0_axi_wstrb[NB], s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

    // ---------------- write path ----------------
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NB-1:0]         w_wr_strb;
    logic                  w_wr_in_range;
    logic                  w_commit;

    assign w_aw_hs  = s0_axi_awvalid & r_awready;
    assign w_w_hs   = s0_axi_wvalid & r_wready;

    // A beat arriving on this edge is used directly, so the write can commit
    // on the same edge as the second of AW/W.
    assign w_wr_idx      = w_aw_hs ? s0_axi_awaddr[ADDR_WIDTH-1:2] : r_aw_idx;
    assign w_wr_data     = w_w_hs ? s0_axi_wdata : r_wdata;
    assign w_wr_strb     = w_w_hs ? s0_axi_wstrb[NB-1:0] : r_wstrb;
    assign w_wr_in_range = (32'(w_wr_idx) < DEPTH_U);
    assign w_commit      = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        if (w_wr_in_range) begin
                            for (int b = 0; b < NB; b++) begin
                                if (w_wr_strb[b]) begin
                                    r_mem[w_wr_idx[MEM_AW-1:0]][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                                end
                            end
                        end
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_in_range;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        // Readies are 0 out of reset and rise on the first edge.
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_idx  <= s0_axi_awaddr[ADDR_WIDTH-1:2];
                            r_awready <= 1'b0;
                        end else if (!r_aw_held) begin
                            r_awready <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s0_axi_wdata;
                            r_wstrb  <= s0_axi_wstrb[NB-1:0];
                            r_wready <= 1'b0;
                        end else if (!r_w_held) begin
                            r_wready <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s0_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    logic             w_ar_hs;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_in_range;

    assign w_ar_hs       = s0_axi_arvalid & r_arready;
    assign w_rd_idx      = s0_axi_araddr[ADDR_WIDTH-1:2];
    assign w_rd_in_range = (32'(w_rd_idx) < DEPTH_U);

    // r_mem is sampled with pre-edge contents, so a read colliding with a
    // write commit on the same edge returns the old word.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        if (w_rd_in_range) begin
                            r_rdata <= r_mem[w_rd_idx[MEM_AW-1:0]];
                        end else begin
                            r_rdata <= '0;
                        end
                        r_rresp   <= w_rd_in_range;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s0_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s0_axi_awready = r_awready;
    assign s0_axi_wready  = r_wready;
    assign s0_axi_bvalid  = r_bvalid;
    assign s0_axi_bresp   = r_bresp;
    assign s0_axi_arready = r_arready;
    assign s0_axi_rvalid  = r_rvalid;
    assign s0_axi_rdata   = r_rdata;
    assign s0_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave (ADDR_WIDTH=9 so out-of-range addresses exist).
// A transaction-level model of the memory and channel occupancy predicts the
// outputs; a monitor compares them every cycle on the falling edge. Directed
// sequences add literal expectations; a random phase exercises overlap.

module tb_axi_lite_mem_slave;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 64;
  localparam int NB    = DW / 8;
  localparam int TMO   = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [NB:0]   wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic          bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rresp;
  logic          rvalid;
  logic          rready = 1'b1;

  axi_lite_mem_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .s0_axi_aclk   (clk),
    .s0_axi_aresetn(rst_n),
    .s0_axi_awaddr (awaddr),
    .s0_axi_awvalid(awvalid),
    .s0_axi_awready(awready),
    .s0_axi_wdata  (wdata),
    .s0_axi_wstrb  (wstrb),
    .s0_axi_wvalid (wvalid),
    .s0_axi_wready (wready),
    .s0_axi_bresp  (bresp),
    .s0_axi_bvalid (bvalid),
    .s0_axi_bready (bready),
    .s0_axi_araddr (araddr),
    .s0_axi_arvalid(arvalid),
    .s0_axi_arready(arready),
    .s0_axi_rdata  (rdata),
    .s0_axi_rresp  (rresp),
    .s0_axi_rvalid (rvalid),
    .s0_axi_rready (rready)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within %0d cycles at %0t", name, TMO, $time);
  endtask

  // ---------------- reference model ----------------
  // Memory contents plus which channel beats are currently owned by the slave.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_live = 0;
  bit            m_aw_have = 0, m_w_have = 0, m_b_pend = 0, m_r_pend = 0;
  bit            m_b_resp = 0, m_r_resp = 0;
  logic [AW-1:0] m_aw_addr = '0;
  logic [DW-1:0] m_w_data = '0, m_r_data = '0;
  logic [NB:0]   m_w_strb = '0;
  bit            h_aw, h_w, h_ar, h_b, h_r;
  int unsigned   h_idx;
  logic [DW-1:0] h_mask;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_live = 0; m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_r_pend = 0;
      m_b_resp = 0; m_r_resp = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      h_aw = awvalid && m_live && !m_aw_have && !m_b_pend;
      h_w  = wvalid && m_live && !m_w_have && !m_b_pend;
      h_ar = arvalid && m_live && !m_r_pend;
      h_b  = m_b_pend && bready;
      h_r  = m_r_pend && rready;
      // read sees memory as it was before this edge
      if (h_ar) begin
        h_idx    = int'(araddr) / 4;
        m_r_resp = (h_idx < DEPTH);
        if (m_r_resp) m_r_data = m_mem[h_idx];
        else          m_r_data = '0;
        m_r_pend = 1;
      end else if (h_r) begin
        m_r_pend = 0;
      end
      if (h_b) m_b_pend = 0;
      if (h_aw) begin m_aw_have = 1; m_aw_addr = awaddr; end
      if (h_w)  begin m_w_have = 1; m_w_data = wdata; m_w_strb = wstrb; end
      if (m_aw_have && m_w_have) begin
        h_idx    = int'(m_aw_addr) / 4;
        m_b_resp = (h_idx < DEPTH);
        if (m_b_resp) begin
          h_mask = '0;
          for (int b = 0; b < NB; b++) if (m_w_strb[b]) h_mask[b*8 +: 8] = 8'hFF;
          m_mem[h_idx] = (m_mem[h_idx] & ~h_mask) | (m_w_data & h_mask);
        end
        m_b_pend = 1; m_aw_have = 0; m_w_have = 0;
      end
      m_live = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, '0);
    end else begin
      chk("awready", awready, m_live && !m_aw_have && !m_b_pend);
      chk("wready",  wready,  m_live && !m_w_have && !m_b_pend);
      chk("bvalid",  bvalid,  m_b_pend);
      chk("arready", arready, m_live && !m_r_pend);
      chk("rvalid",  rvalid,  m_r_pend);
      if (m_b_pend) chk("bresp", bresp, m_b_resp);
      if (m_r_pend) begin
        chk("rdata", rdata, m_r_data);
        chk("rresp", rresp, m_r_resp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic do_aw(input logic [AW-1:0] a, input int dly);
    int t;
    repeat (dly) @(posedge clk);
    #1;
    awaddr = a; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) fail_to("aw_wait");
    @(posedge clk); #1;
    awvalid = 1'b0; awaddr = AW'($urandom);
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [NB:0] s, input int dly);
    int t;
    repeat (dly) @(posedge clk);
    #1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!wready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) fail_to("w_wait");
    @(posedge clk); #1;
    wvalid = 1'b0; wdata = $urandom;
  endtask

  task automatic wait_b(output logic resp, output int lat);
    lat = 0;
    @(negedge clk);
    while (!(bvalid && bready) && lat < TMO) begin @(negedge clk); lat++; end
    if (lat >= TMO) fail_to("b_wait");
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB:0] s,
                           input int aw_dly, input int w_dly, output logic resp, output int lat);
    fork
      do_aw(a, aw_dly);
      do_w(d, s, w_dly);
    join
    wait_b(resp, lat);
  endtask

  task automatic start_ar(input logic [AW-1:0] a);
    int t;
    #1;
    araddr = a; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) fail_to("ar_wait");
    @(posedge clk); #1;
    arvalid = 1'b0; araddr = AW'($urandom);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic resp,
                          output int lat);
    start_ar(a);
    lat = 0;
    @(negedge clk);
    while (!(rvalid && rready) && lat < TMO) begin @(negedge clk); lat++; end
    if (lat >= TMO) fail_to("r_wait");
    d = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  // ---------------- random phase helpers ----------------
  bit rnd_on = 0;

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(256, 511));
    return AW'($urandom_range(0, 255));
  endfunction

  task automatic rnd_writer(input int n);
    logic r; int l;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      axi_write(rnd_addr(), $urandom, NB'(0) + 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom_range(0, 3), r, l);
    end
  endtask

  task automatic rnd_reader(input int n);
    logic [DW-1:0] d; logic r; int l;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      axi_read(rnd_addr(), d, r, l);
    end
  endtask

  task automatic rnd_backpressure();
    while (rnd_on) begin
      @(posedge clk); #1;
      if (rnd_on) begin
        bready = ($urandom_range(0, 3) != 0);
        rready = ($urandom_range(0, 3) != 0);
      end
    end
    bready = 1'b1; rready = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic          r;
    int            lat;

    // reset and ready bring-up
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_before_first_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    chk("ready_after_first_edge", {awready, wready, arready}, 3'b111);

    // basic write + read, AW and W together
    axi_write(9'h010, 32'hDEADBEEF, 5'h0F, 0, 0, r, lat);
    chk("wr1_bresp", r, 1'b1);
    chk("wr1_latency", lat, 0);
    axi_read(9'h010, d, r, lat);
    chk("rd1_data", d, 32'hDEADBEEF);
    chk("rd1_rresp", r, 1'b1);
    chk("rd1_latency", lat, 0);

    // partial strobes
    axi_write(9'h020, 32'h11223344, 5'h0F, 0, 0, r, lat);
    axi_write(9'h022, 32'hAABBCCDD, 5'h05, 0, 0, r, lat);
    axi_read(9'h020, d, r, lat);
    chk("strobe_0x5_data", d, 32'h11BB33DD);
    // no enabled byte (only the ignored MSB): OKAY, no change
    axi_write(9'h020, 32'hFFFFFFFF, 5'h10, 0, 0, r, lat);
    chk("strobe_none_bresp", r, 1'b1);
    axi_read(9'h020, d, r, lat);
    chk("strobe_none_data", d, 32'h11BB33DD);

    // order independence
    axi_write(9'h024, 32'hCAFEF00D, 5'h0F, 3, 0, r, lat);
    chk("w_first_bresp", r, 1'b1);
    chk("w_first_latency", lat, 0);
    axi_read(9'h024, d, r, lat);
    chk("w_first_data", d, 32'hCAFEF00D);
    axi_write(9'h024, 32'h0BADF00D, 5'h0F, 0, 2, r, lat);
    chk("aw_first_latency", lat, 0);
    axi_read(9'h024, d, r, lat);
    chk("aw_first_data", d, 32'h0BADF00D);

    // out of range
    axi_write(9'h100, 32'hFFFFFFFF, 5'h0F, 0, 0, r, lat);
    chk("oor_bresp", r, 1'b0);
    axi_read(9'h100, d, r, lat);
    chk("oor_rdata", d, 32'h0);
    chk("oor_rresp", r, 1'b0);
    axi_read(9'h000, d, r, lat);
    chk("oor_no_alias_word0", d, 32'h0);

    // read backpressure
    rready = 1'b0;
    start_ar(9'h010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstall_rvalid", rvalid, 1'b1);
      chk("rstall_rdata", rdata, 32'hDEADBEEF);
      chk("rstall_arready", arready, 1'b0);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(negedge clk);
    chk("rstall_release_rvalid", rvalid, 1'b1);
    @(negedge clk);
    chk("rstall_after_arready", {arready, rvalid}, 2'b10);
    @(posedge clk); #1;

    // write backpressure
    bready = 1'b0;
    fork
      do_aw(9'h030, 0);
      do_w(32'h12345678, 5'h0F, 0);
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bstall_bvalid", bvalid, 1'b1);
      chk("bstall_bresp", bresp, 1'b1);
      chk("bstall_readies", {awready, wready}, 2'b00);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    chk("bstall_release_bvalid", bvalid, 1'b1);
    @(negedge clk);
    chk("bstall_after", {awready, wready, bvalid}, 3'b110);
    @(posedge clk); #1;
    axi_read(9'h030, d, r, lat);
    chk("bstall_data", d, 32'h12345678);

    // read/write collision on word 2
    begin
      logic [DW-1:0] cd; logic cr; int cl; logic wr; int wl;
      fork
        axi_write(9'h008, 32'h00000055, 5'h0F, 0, 0, wr, wl);
        axi_read(9'h008, cd, cr, cl);
      join
      chk("collide_old_data", cd, 32'h0);
      axi_read(9'h008, d, r, lat);
      chk("collide_new_data", d, 32'h55);
    end

    // randomized overlapping traffic with random backpressure
    rnd_on = 1;
    fork
      rnd_backpressure();
    join_none
    fork
      rnd_writer(120);
      rnd_reader(120);
    join
    rnd_on = 0;
    repeat (3) begin @(posedge clk); #1; end

    // reset during R_DATA
    rready = 1'b0;
    start_ar(9'h024);
    @(negedge clk);
    chk("pre_reset_rvalid", rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_rvalid", rvalid, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(AW'(i * 4), d, r, lat);
      chk("post_reset_mem_zero", d, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI4-Lite memory-mapped slave: a word-addressed register memory with byte strobes.
- Sits directly downstream of the bus bridge and terminates its master (m1) port: bridge m1_* connects to this block's s0_* ports.
- Independent write and read FSMs, one outstanding transaction per channel, registered responses.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 8, byte address width.
- MEM_DEPTH, 64, number of DATA_WIDTH words; must be ≤ 2^(ADDR_WIDTH-2).

Ports:
- s0_axi_aclk  in  1  sole clock; all logic on rising edge.
- s0_axi_aresetn  in  1  asynchronous, active-low reset.
- s0_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s0_axi_awvalid  in  1  write address valid.
- s0_axi_awready  out  1  write address ready.
- s0_axi_wdata  in  DATA_WIDTH  write data.
- s0_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; MSB ignored.
- s0_axi_wvalid  in  1  write data valid.
- s0_axi_wready  out  1  write data ready.
- s0_axi_bresp  out  1  1 = OKAY, 0 = error.
- s0_axi_bvalid  out  1  write response valid.
- s0_axi_bready  in  1  write response ready.
- s0_axi_araddr  in  ADDR_WIDTH  read byte address.
- s0_axi_arvalid  in  1  read address valid.
- s0_axi_arready  out  1  read address ready.
- s0_axi_rdata  out  DATA_WIDTH  read data.
- s0_axi_rresp  out  1  1 = OKAY, 0 = error.
- s0_axi_rvalid  out  1  read data valid.
- s0_axi_rready  in  1  read data ready.

Behaviour:
- Reset (async assert, release sync to clock):
  - All outputs 0.
  - Memory words cleared to 0.
  - FSMs go to idle.
  - awready, wready and arready rise on the first clock edge after release.
- Addressing:
  - word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - index ≥ MEM_DEPTH is out of range.
- Write FSM W_IDLE -> W_RESP -> W_IDLE:
  - W_IDLE: awready = 1 until the AW handshake (awvalid & awready), then 0 and awaddr is latched. wready = 1 until the W handshake, then 0 and wdata/wstrb are latched. AW and W may arrive in either order or in the same cycle.
  - When both are held (including the edge where the second arrives), the memory write commits on that edge. Only strobed bytes are written; if out of range, nothing is written.
  - The FSM then enters W_RESP with bvalid = 1 and bresp = 1 (in range) or 0 (out of range).
  - W_RESP: bvalid and bresp stay stable until bready. On the bvalid & bready edge: bvalid -> 0, awready and wready -> 1, state -> W_IDLE.
  - Minimum latency: bvalid is seen 1 cycle after the edge completing AW+W. Throughput: 1 write per 2 cycles.
  - wstrb = 0 with an in-range address: no memory change, bresp = 1.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready = 1. On the AR handshake edge: rdata is registered from the memory word (pre-edge contents), or 0 if out of range; rresp = 1/0 accordingly; rvalid -> 1; arready -> 0; state -> R_DATA.
  - R_DATA: rdata, rresp and rvalid stay stable until rready. On the rvalid & rready edge: rvalid -> 0, arready -> 1, state -> R_IDLE.
  - Minimum latency: AR to rvalid is 1 cycle.
- Simultaneous events:
  - Read and write channels are fully independent; a read and a write may complete on the same edge.
  - A read handshake on the same edge as a write commit to the same word returns the old data. A read on any later edge returns the new data.
- Reset mid-transaction: pending AW/W/B/AR/R state is discarded, valids drop to 0 asynchronously, and a half-latched write (AW only or W only) never commits.
- Backpressure: a master holding bready/rready low stalls only its own channel.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with wstrb 0xF (AW and W in the same cycle), bready=1 -> bvalid 1 cycle later, bresp=1. Then read 0x10 -> rvalid 1 cycle after AR, rdata=0xDEADBEEF, rresp=1.
- Partial strobes: preload 0x11223344 at 0x20, then write 0xAABBCCDD with wstrb 0x5 -> read 0x20 returns 0x11BB33DD.
- Order independence: W first, AW 3 cycles later -> commit on the AW edge, a single bvalid pulse. Then AW first, W 2 cycles later -> same result. Reading 0x24 after writing 0x24 returns the written data.
- Out of range (MEM_DEPTH=64): write to 0x100 (ADDR_WIDTH=9) -> bresp=0, no word changes. Read 0x100 -> rdata=0, rresp=0.
- Backpressure: hold rready=0 for 5 cycles -> rvalid/rdata stable and arready=0 throughout; release -> arready=1 next cycle. Same check with bready.
- Read/write collision: 0x08 holds 0x0; AR to 0x08 on the same edge as a write commit of 0x55 -> rdata=0x0; the next read returns 0x55. Assert reset mid-R_DATA -> rvalid=0 immediately, memory all zero after release.
